// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 compression core, one round per clock
// Chaining value H is kept across blocks unless the block Index restarts the message.
module sha256_compress #(
  parameter int NI = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [511:0]   Data,
  input  logic [NI-1:0]  Index,
  input  logic           Valid,
  output logic           Busy,
  output logic [255:0]   Hash,
  output logic           Hash_Valid
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t      state;
  logic [5:0]  t;
  logic [31:0] h_reg [8];
  logic [31:0] v [8];   // working variables a..h
  logic [31:0] w [16];  // w[0] is W_t
  logic [31:0] t1, t2, w_next;

  always_comb begin
    t1     = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[0];
    t2     = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  assign Busy = (state != IDLE);
  assign Hash = {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      t          <= '0;
      Hash_Valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i] <= '0;
        v[i]     <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      Hash_Valid <= 1'b0;
      case (state)
        IDLE: if (Valid) begin
          state <= ROUND;
          t     <= '0;
          for (int i = 0; i < 16; i++)
            w[i] <= {Data[i*32+:8], Data[i*32+8+:8], Data[i*32+16+:8], Data[i*32+24+:8]};
          for (int i = 0; i < 8; i++) begin
            if (Index == '0) begin
              h_reg[i] <= IV[i];
              v[i]     <= IV[i];
            end else begin
              v[i]     <= h_reg[i];
            end
          end
        end
        ROUND: begin
          v[7] <= v[6];
          v[6] <= v[5];
          v[5] <= v[4];
          v[4] <= v[3] + t1;
          v[3] <= v[2];
          v[2] <= v[1];
          v[1] <= v[0];
          v[0] <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          t     <= t + 6'd1;
          if (t == 6'd63) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v[i];
          Hash_Valid <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - randomized and known-answer bench for sha256_compress
// Reference model computes full FIPS 180-4 compression on a 64-word schedule.
module tb_sha256_compress;

  logic         clk;
  logic         rst;
  logic [511:0] Data;
  logic [63:0]  Index;
  logic         Valid;
  logic         Busy;
  logic [255:0] Hash;
  logic         Hash_Valid;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] model_h;

  localparam logic [255:0] IV_ALL = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_compress #(.NI(64)) dut (
    .clk(clk), .rst(rst), .Data(Data), .Index(Index), .Valid(Valid),
    .Busy(Busy), .Hash(Hash), .Hash_Valid(Hash_Valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++)
      w[i] = {blk[i*32+:8], blk[i*32+8+:8], blk[i*32+16+:8], blk[i*32+24+:8]};
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int k = 0; k < 8; k++) hv[k] = hin[255-32*k -: 32];
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] abc_block();
    logic [511:0] b;
    b = '0;
    b[31:0]    = 32'h80636261;
    b[511:480] = 32'h18000000;
    return b;
  endfunction

  function automatic logic [255:0] model_step(input logic [63:0] idx, input logic [511:0] blk);
    model_h = ref_compress((idx == 64'd0) ? IV_ALL : model_h, blk);
    return model_h;
  endfunction

  // Presents one block for one cycle, corrupts Data afterwards, returns cycles to Hash_Valid (0 = timeout).
  task automatic run_block(input logic [511:0] d, input logic [63:0] idx, output int lat);
    @(negedge clk);
    Data = d; Index = idx; Valid = 1'b1; lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        Valid = 1'b0;
        Data  = rand512();
        Index = {$urandom, $urandom};
      end
      if (Hash_Valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; Valid = 1'b0; Data = '0; Index = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({Busy, Hash_Valid} !== 2'b00) $display("FAIL reset_ctrl: got %b want 00", {Busy, Hash_Valid}); else n_pass++;
    n_checks++; if (Hash !== 256'd0) $display("FAIL reset_hash: got %h want 0", Hash); else n_pass++;
    rst = 1'b1;
    model_h = '0;
  endtask

  task automatic test_abc();
    int lat;
    logic [255:0] exp;
    exp = model_step(64'd0, abc_block());
    run_block(abc_block(), 64'd0, lat);
    n_checks++; if (lat !== 66) $display("FAIL abc_latency: got %0d want 66", lat); else n_pass++;
    n_checks++; if (Hash !== ABC_DIG) $display("FAIL abc_digest: got %h want %h", Hash, ABC_DIG); else n_pass++;
    n_checks++; if (Hash !== exp) $display("FAIL abc_model: got %h want %h", Hash, exp); else n_pass++;
    @(negedge clk);
    n_checks++; if ({Busy, Hash_Valid} !== 2'b00) $display("FAIL abc_after_done: got %b want 00", {Busy, Hash_Valid}); else n_pass++;
  endtask

  task automatic test_empty();
    int lat;
    logic [511:0] b;
    b = '0;
    b[31:0] = 32'h00000080;
    run_block(b, 64'd0, lat);
    void'(model_step(64'd0, b));
    n_checks++; if (lat !== 66) $display("FAIL empty_latency: got %0d want 66", lat); else n_pass++;
    n_checks++; if (Hash !== EMPTY_DIG) $display("FAIL empty_digest: got %h want %h", Hash, EMPTY_DIG); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    string s;
    logic [511:0] b1, b2;
    logic [255:0] mid;
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    b1 = '0; b2 = '0;
    for (int j = 0; j < s.len(); j++) b1[j*8+:8] = s[j];
    b1[56*8+:8] = 8'h80;
    b2[62*8+:8] = 8'h01;
    b2[63*8+:8] = 8'hc0;
    mid = model_step(64'd0, b1);
    run_block(b1, 64'd0, lat1);
    n_checks++; if (Hash !== mid) $display("FAIL two_block_mid: got %h want %h", Hash, mid); else n_pass++;
    run_block(b2, 64'd1, lat2);
    void'(model_step(64'd1, b2));
    n_checks++; if ({lat1, lat2} !== {32'd66, 32'd66}) $display("FAIL two_block_latency: got %0d,%0d want 66,66", lat1, lat2); else n_pass++;
    n_checks++; if (Hash !== TWO_DIG) $display("FAIL two_block_digest: got %h want %h", Hash, TWO_DIG); else n_pass++;
  endtask

  task automatic test_valid_held();
    int busy_err, hv_err, hash_err, accepts;
    logic [255:0] exp_q [$];
    logic [255:0] exp;
    logic [63:0] idx;
    logic [511:0] blk;
    busy_err = 0; hv_err = 0; hash_err = 0; accepts = 0;
    for (int i = 0; i < 3 * 67; i++) begin
      @(negedge clk);
      if (Busy !== ((i % 67) != 0)) busy_err++;
      if (Hash_Valid !== ((i % 67) == 66)) hv_err++;
      if ((i % 67) == 66) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 256'd0;
        if (Hash !== exp) begin
          hash_err++;
          $display("FAIL held_digest: got %h want %h", Hash, exp);
        end
        if (i == 66 && Hash !== ABC_DIG) begin
          hash_err++;
          $display("FAIL held_abc: got %h want %h", Hash, ABC_DIG);
        end
      end
      blk = (i == 0) ? abc_block() : rand512();
      idx = (i == 0) ? 64'd0 : {$urandom, $urandom};
      Data = blk; Index = idx;
      Valid = (i != 3 * 67 - 1);
      if ((i % 67) == 0) begin
        exp_q.push_back(model_step(idx, blk));
        accepts++;
      end
    end
    n_checks++; if (busy_err !== 0) $display("FAIL held_busy: got %0d bad cycles want 0", busy_err); else n_pass++;
    n_checks++; if (hv_err !== 0) $display("FAIL held_pulses: got %0d bad cycles want 0", hv_err); else n_pass++;
    n_checks++; if (hash_err !== 0 || accepts !== 3) $display("FAIL held_hash: got %0d errors want 0", hash_err); else n_pass++;
  endtask

  task automatic test_reset_mid_round();
    int lat, stray;
    @(negedge clk);
    Data = abc_block(); Index = '0; Valid = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      Valid = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_h = '0;
    n_checks++; if ({Busy, Hash_Valid} !== 2'b00) $display("FAIL midreset_ctrl: got %b want 00", {Busy, Hash_Valid}); else n_pass++;
    n_checks++; if (Hash !== 256'd0) $display("FAIL midreset_hash: got %h want 0", Hash); else n_pass++;
    stray = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (Hash_Valid !== 1'b0 || Busy !== 1'b0) stray++;
    end
    n_checks++; if (stray !== 0) $display("FAIL midreset_stray: got %0d active cycles want 0", stray); else n_pass++;
    run_block(abc_block(), 64'd0, lat);
    void'(model_step(64'd0, abc_block()));
    n_checks++; if (lat !== 66 || Hash !== ABC_DIG) $display("FAIL midreset_abc: got %h lat %0d want %h lat 66", Hash, lat, ABC_DIG); else n_pass++;
  endtask

  task automatic test_chain_from_zero();
    int lat;
    logic [255:0] exp;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_h = '0;
    exp = model_step(64'd1, abc_block());
    run_block(abc_block(), 64'd1, lat);
    n_checks++; if (lat !== 66 || Hash !== exp) $display("FAIL zero_chain: got %h lat %0d want %h lat 66", Hash, lat, exp); else n_pass++;
    n_checks++; if ($isunknown({Busy, Hash, Hash_Valid}) !== 1'b0) $display("FAIL zero_chain_x: got unknown on outputs want none"); else n_pass++;
  endtask

  task automatic test_random_chain();
    int lat;
    logic [511:0] blk;
    logic [63:0] idx;
    logic [255:0] exp;
    for (int k = 0; k < 5; k++) begin
      blk = rand512();
      idx = (k == 0 || k == 3) ? 64'd0 : {$urandom, $urandom | 32'd1};
      exp = model_step(idx, blk);
      run_block(blk, idx, lat);
      n_checks++; if (lat !== 66 || Hash !== exp) $display("FAIL random_block%0d: got %h lat %0d want %h lat 66", k, Hash, lat, exp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_valid_held();
    test_reset_mid_round();
    test_chain_from_zero();
    test_random_chain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 Parameter NI, default 64, gives the width of the block sequence number Index.
REQ-002 Reset is rst, synchronous, active-low; the clock is clk.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-low reset.
REQ-005 Port Data, input, 512 bits: padded message block; word i = Data[i*32+:32], message byte 4i in bits [7:0], byte 4i+3 in bits [31:24].
REQ-006 Port Index, input, NI bits: block sequence number; 0 marks the first block of a message.
REQ-007 Port Valid, input, 1 bit: Data and Index are valid this cycle (driven by the block formatter's Ready).
REQ-008 Port Busy, output, 1 bit: 1 whenever the block is not in IDLE.
REQ-009 Port Hash, output, 256 bits: chaining value; H0 in [255:224] through H7 in [31:0].
REQ-010 Port Hash_Valid, output, 1 bit: one-cycle pulse; Hash is updated for the last accepted block.

Function
REQ-011 The state machine SHALL have four states: IDLE, ROUND, UPDATE and DONE.
REQ-012 IDLE with Valid=1: the block SHALL accept on that edge and move to ROUND with round counter t=0.
REQ-013 On the accepting edge the W window SHALL load 16 words, each byte-swapped to big-endian: W[i] = {Data[i*32+:8], Data[i*32+8+:8], Data[i*32+16+:8], Data[i*32+24+:8]}.
REQ-014 On the accepting edge with Index==0, the H registers SHALL load the FIPS 180-4 SHA-256 IV and working variables a..h SHALL load the IV.
REQ-015 On the accepting edge with Index!=0, a..h SHALL load the current H registers and H SHALL be unchanged.
REQ-016 ROUND SHALL execute one FIPS 180-4 round per cycle using K[t] and W_t, for exactly 64 cycles (t=0..63).
REQ-017 W_t for t<16 SHALL be the loaded word; for t>=16, W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}, held in a 16-entry shifting window.
REQ-018 All additions SHALL be modulo 2^32 with no saturation or carry-out.
REQ-019 After t=63, ROUND SHALL move to UPDATE.
REQ-020 UPDATE SHALL compute Hk <= Hk + (a..h)k modulo 2^32 and move to DONE.
REQ-021 DONE SHALL assert Hash_Valid=1 for exactly that one cycle and then return to IDLE.
REQ-022 Latency SHALL be fixed: Hash_Valid is high in the 66th cycle after the accepting edge (64 ROUND + 1 UPDATE + DONE).
REQ-023 Hash SHALL always reflect the H registers and SHALL change only on the UPDATE edge or the Index==0 accept edge.
REQ-024 Valid SHALL be ignored in ROUND, UPDATE and DONE; Data and Index are not sampled there.
REQ-025 Valid in the cycle following DONE (IDLE) SHALL be accepted, so back-to-back blocks run every 67 cycles.
REQ-026 Busy SHALL be a function of the registered state only, with no combinational path from Valid.
REQ-027 Data may change after the accepting edge without affecting the result.

Reset
REQ-028 rst=0 at a clock edge SHALL force state IDLE, t=0, Busy=0, Hash_Valid=0, H registers=0, a..h=0 and W=0.
REQ-029 Reset asserted mid-ROUND or mid-UPDATE SHALL abort the block with no Hash_Valid pulse and lose the chaining value.
REQ-030 After reset, an accepted block with Index!=0 SHALL chain from H=0 (defined, not an error).

Verification
REQ-031 "abc" single block: Data[31:0]=0x80636261, Data[511:480]=0x18000000, all other bits 0, Index=0, Valid pulse -> Hash_Valid 66 cycles later, Hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-032 Empty message: Data[31:0]=0x00000080, rest 0, Index=0 -> Hash=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-033 Two-block 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with Index 0 then 1, second Valid in the cycle after DONE -> one Hash_Valid per block; final Hash=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-034 Valid held high continuously with Data changing every cycle during ROUND -> exactly one accept per 67 cycles; "abc" result unchanged when Data is corrupted after the accept.
REQ-035 rst=0 at ROUND t=30 -> next cycle Busy=0, Hash=0, no Hash_Valid; a following "abc" block with Index=0 gives the correct digest.
REQ-036 After reset, "abc" block with Index=1 -> digest equals the compression of that block from H=0 (reference model), with no X on any output.
